// File: rtl/mem_arbiter_pkg.sv
// Shared encodings, types and request builders for the memory bus arbiter.
package mem_arbiter_pkg;

    localparam int MEM_ARB_WAIT_DEFAULT = 2;

    localparam logic [1:0] MemArbIdle   = 2'd0;
    localparam logic [1:0] MemArbAccess = 2'd1;
    localparam logic [1:0] MemArbDone   = 2'd2;

    typedef logic [29:0] word_addr_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } bus_req_t;

    function automatic bus_req_t data_req(input logic        we,
                                          input logic [31:0] addr,
                                          input logic [3:0]  sel,
                                          input logic [31:0] data);
        bus_req_t r;
        r.we   = we;
        r.addr = addr;
        r.sel  = sel;
        r.data = data;
        return r;
    endfunction

    // Fetches always read a full word.
    function automatic bus_req_t fetch_req(input logic [31:0] addr);
        bus_req_t r;
        r.we   = 1'b0;
        r.addr = addr;
        r.sel  = 4'b1111;
        r.data = 32'h0;
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_ibuf.sv
// One-entry instruction buffer: last fetched word address and data, with
// invalidation on a matching store or on flush. Used under MEM_ARB_IBUF_EN.
module mem_arb_ibuf
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  word_addr_t  lookup_word_i,
    input  logic        fill_en_i,
    input  word_addr_t  fill_word_i,
    input  logic [31:0] fill_data_i,
    input  logic        inv_en_i,
    input  word_addr_t  inv_word_i,
    output logic        hit_o,
    output logic [31:0] data_o
);

    logic        valid_q, valid_d;
    word_addr_t  tag_q, tag_d;
    logic [31:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en_i) begin
            valid_d = 1'b1;
            tag_d   = fill_word_i;
            data_d  = fill_data_i;
        end
        if (flush_i || (inv_en_i && (inv_word_i == tag_q))) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_word_i);
    assign data_o = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the external SRAM bus between instruction fetch and MEM-stage
// accesses with wait states and a stall request. MEM_ARB_IBUF_EN adds a fetch buffer.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = MEM_ARB_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ready_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ready_o,
    input  logic        flush_i,
    output logic        bus_ce_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    output logic        stallreq_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_mem_q, grant_mem_d;
    logic        discard_q, discard_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        bus_ce_q, bus_ce_d;
    bus_req_t    bus_q, bus_d;

    logic        mem_pend, if_pend, stall;
    logic        launch_mem, launch_if, discard_now;
    logic        ibuf_hit;
    logic [31:0] ibuf_data;

    assign mem_pend    = mem_ce_i & ~mem_done_q;
    assign if_pend     = if_ce_i & ~if_done_q;
    assign stall       = mem_pend | if_pend;
    assign discard_now = discard_q | flush_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_mem_d = grant_mem_q;
        discard_d   = discard_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        if_data_d   = if_data_q;
        mem_data_d  = mem_data_q;
        bus_ce_d    = bus_ce_q;
        bus_d       = bus_q;
        launch_mem  = 1'b0;
        launch_if   = 1'b0;

        // Flags drop after the pipeline advances (stall low) or on a flush.
        if (!stall || flush_i) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
        end

        case (state_q)
            MemArbIdle: begin
                if (!flush_i) begin
                    if (mem_pend) begin
                        launch_mem = 1'b1;
                    end else if (if_pend && ibuf_hit) begin
                        if_done_d = 1'b1;
                        if_data_d = ibuf_data;
                    end else if (if_pend) begin
                        launch_if = 1'b1;
                    end
                end
                if (launch_mem || launch_if) begin
                    state_d     = MemArbAccess;
                    cnt_d       = WAIT_LOAD;
                    grant_mem_d = launch_mem;
                    discard_d   = 1'b0;
                    bus_ce_d    = 1'b1;
                    bus_d       = launch_mem ? data_req(mem_we_i, mem_addr_i, mem_sel_i, mem_data_i)
                                             : fetch_req(if_addr_i);
                end
            end
            MemArbAccess: begin
                // A flushed access still runs to completion so writes are never torn.
                if (flush_i) begin
                    discard_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    state_d  = MemArbDone;
                    bus_ce_d = 1'b0;
                    bus_d    = '0;
                    if (!discard_now) begin
                        if (grant_mem_q) begin
                            mem_done_d = 1'b1;
                            if (!bus_q.we) begin
                                mem_data_d = bus_data_i;
                            end
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = bus_data_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MemArbDone: begin
                state_d   = MemArbIdle;
                discard_d = 1'b0;
            end
            default: begin
                state_d = MemArbIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MemArbIdle;
            cnt_q       <= '0;
            grant_mem_q <= 1'b0;
            discard_q   <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_data_q  <= '0;
            bus_ce_q    <= 1'b0;
            bus_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_mem_q <= grant_mem_d;
            discard_q   <= discard_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_data_q  <= mem_data_d;
            bus_ce_q    <= bus_ce_d;
            bus_q       <= bus_d;
        end
    end

`ifdef MEM_ARB_IBUF_EN
    logic ibuf_fill;
    logic ibuf_inv;

    assign ibuf_fill = (state_q == MemArbAccess) && (cnt_q == 4'd0) && !grant_mem_q && !discard_now;
    assign ibuf_inv  = launch_mem && mem_we_i;

    mem_arb_ibuf u_ibuf (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .lookup_word_i (if_addr_i[31:2]),
        .fill_en_i     (ibuf_fill),
        .fill_word_i   (bus_q.addr[31:2]),
        .fill_data_i   (bus_data_i),
        .inv_en_i      (ibuf_inv),
        .inv_word_i    (mem_addr_i[31:2]),
        .hit_o         (ibuf_hit),
        .data_o        (ibuf_data)
    );
`else
    assign ibuf_hit  = 1'b0;
    assign ibuf_data = '0;
`endif

    assign if_data_o   = if_data_q;
    assign if_ready_o  = if_done_q;
    assign mem_data_o  = mem_data_q;
    assign mem_ready_o = mem_done_q;
    assign bus_ce_o    = bus_ce_q;
    assign bus_we_o    = bus_q.we;
    assign bus_addr_o  = bus_q.addr;
    assign bus_sel_o   = bus_q.sel;
    assign bus_data_o  = bus_q.data;
    assign stallreq_o  = stall;

endmodule
